// File: rtl/beat_voice_pkg.sv
// Shared types and per-intensity tables for the beat_voice hit synthesiser.
// Tables are indexed by the 2-bit beat intensity; intensity 0 never starts a hit.
package beat_voice_pkg;

    localparam int SAMPLE_W = 16;
    localparam int AMP_W    = 15;
    localparam int HP_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    function automatic logic [AMP_W-1:0] amp_of(input logic [1:0] intensity);
        case (intensity)
            2'd1:    return 15'd8000;
            2'd2:    return 15'd16000;
            2'd3:    return 15'd30000;
            default: return '0;
        endcase
    endfunction

    // Non-zero default keeps the oscillator's wrap compare well defined while idle.
    function automatic logic [HP_W-1:0] hp_of(input logic [1:0] intensity);
        case (intensity)
            2'd1:    return 6'd55;
            2'd2:    return 6'd40;
            2'd3:    return 6'd27;
            default: return 6'd1;
        endcase
    endfunction

endpackage

// File: rtl/beat_voice_if.sv
// Beat input, sample request and sample output bundle between beat_voice and its neighbours.
// slave = the voice itself, master = the beat source / codec side driving it.
interface beat_voice_if;

    logic                                 beat_en;
    logic [1:0]                           beat_intensity;
    logic                                 sample_req;
    logic [beat_voice_pkg::SAMPLE_W-1:0]  sample_out;
    logic                                 sample_valid;
    logic                                 busy;

    modport slave (
        input  beat_en,
        input  beat_intensity,
        input  sample_req,
        output sample_out,
        output sample_valid,
        output busy
    );

    modport master (
        output beat_en,
        output beat_intensity,
        output sample_req,
        input  sample_out,
        input  sample_valid,
        input  busy
    );

endinterface

// File: rtl/beat_voice_osc.sv
// Square-wave phase counter: polarity toggles every half_period advances (0 = positive half).
// Registered, updates on the advance edge; restart wins over advance; no backpressure.
module beat_voice_osc
    import beat_voice_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic            advance,
    input  logic [HP_W-1:0] half_period,
    output logic            polarity
);

    logic [HP_W-1:0] phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= '0;
            polarity <= 1'b0;
        end else if (restart) begin
            phase    <= '0;
            polarity <= 1'b0;
        end else if (advance) begin
            if (phase == half_period - HP_W'(1)) begin
                phase    <= '0;
                polarity <= ~polarity;
            end else begin
                phase <= phase + HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/beat_voice.sv
// Beat-triggered square-wave hit voice; one registered sample 1 cycle after each sample_req, no backpressure.
// BEAT_VOICE_DECAY_EN adds the exponential DECAY phase; without it a hit ends right after the hold.
module beat_voice
    import beat_voice_pkg::*;
#(
    parameter int HOLD_SAMPLES = 2400,
    parameter int DECAY_SHIFT  = 6,
    parameter int MIN_AMP      = 64
) (
    input  logic          clk,
    input  logic          rst,
    beat_voice_if.slave   bus
);

    localparam int                HOLD_W    = $clog2(HOLD_SAMPLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);

    // Decay must always remove at least 1 LSB, otherwise the hit could never end.
    if (MIN_AMP < (1 << DECAY_SHIFT)) begin : g_bad_cfg
        $error("beat_voice: MIN_AMP must be >= (1 << DECAY_SHIFT)");
    end

    state_t              state, state_nx;
    logic [AMP_W-1:0]    amp, amp_nx;
    logic [HOLD_W-1:0]   hold_cnt, hold_nx;
    logic [1:0]          lat_int, lat_nx;
    logic [SAMPLE_W-1:0] out_q, out_nx;
    logic                vld_q, vld_nx;
    logic                trigger, accept, restart, polarity;
    logic [SAMPLE_W-1:0] amp_ext;

`ifdef BEAT_VOICE_DECAY_EN
    localparam logic [AMP_W-1:0] MIN_AMP_V = AMP_W'(MIN_AMP);
    logic [AMP_W-1:0] amp_dec;
    assign amp_dec = amp - (amp >> DECAY_SHIFT);
`endif

    assign trigger = bus.beat_en && (bus.beat_intensity != 2'd0);
    assign accept  = trigger && ((state == ST_IDLE) || (bus.beat_intensity >= lat_int));
    assign amp_ext = {1'b0, amp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            amp      <= '0;
            hold_cnt <= '0;
            lat_int  <= '0;
            out_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            amp      <= amp_nx;
            hold_cnt <= hold_nx;
            lat_int  <= lat_nx;
            out_q    <= out_nx;
            vld_q    <= vld_nx;
        end
    end

    always_comb begin
        state_nx = state;
        amp_nx   = amp;
        hold_nx  = hold_cnt;
        lat_nx   = lat_int;
        out_nx   = out_q;
        vld_nx   = 1'b0;
        restart  = 1'b0;

        if (bus.sample_req) begin
            vld_nx = 1'b1;
            if (state == ST_IDLE) begin
                out_nx = '0;
            end else begin
                out_nx = polarity ? -amp_ext : amp_ext;
            end

            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nx = '0;
`ifdef BEAT_VOICE_DECAY_EN
                        state_nx = ST_DECAY;
`else
                        state_nx = ST_IDLE;
                        amp_nx   = '0;
                        lat_nx   = '0;
`endif
                    end else begin
                        hold_nx = hold_cnt + HOLD_W'(1);
                    end
                end
`ifdef BEAT_VOICE_DECAY_EN
                ST_DECAY: begin
                    amp_nx = amp_dec;
                    if (amp_dec < MIN_AMP_V) begin
                        state_nx = ST_IDLE;
                        amp_nx   = '0;
                        lat_nx   = '0;
                    end
                end
`endif
                default: ;
            endcase
        end

        // A same-cycle request already used the old state above; the trigger shapes the next one.
        if (accept) begin
            state_nx = ST_HOLD;
            amp_nx   = amp_of(bus.beat_intensity);
            hold_nx  = '0;
            lat_nx   = bus.beat_intensity;
            restart  = 1'b1;
        end
    end

    beat_voice_osc u_osc (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart),
        .advance     (bus.sample_req && (state != ST_IDLE)),
        .half_period (hp_of(lat_int)),
        .polarity    (polarity)
    );

    assign bus.sample_out   = out_q;
    assign bus.sample_valid = vld_q;
    assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_beat_voice.sv
// Scoreboarded bench for beat_voice: requests push expected samples, a monitor pops on sample_valid.
module tb_beat_voice;

    localparam int HOLD  = 2400;
    localparam int SHIFT = 6;
    localparam int MINA  = 64;

    typedef struct {
        int    val;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic req_seen;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    beat_voice_if bus();

    beat_voice #(
        .HOLD_SAMPLES (HOLD),
        .DECAY_SHIFT  (SHIFT),
        .MIN_AMP      (MINA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Expected sample k (1-based) of an undisturbed hit; 0 once the hit has ended.
    function automatic int hit_sample(input int amp0, input int hp, input int k);
        int mag;
        if (k <= HOLD) begin
            mag = amp0;
        end else begin
`ifdef BEAT_VOICE_DECAY_EN
            mag = amp0;
            for (int j = HOLD + 1; j < k; j++) begin
                mag = mag - (mag >>> SHIFT);
                if (mag < MINA) return 0;
            end
`else
            return 0;
`endif
        end
        return ((((k - 1) / hp) % 2) == 1) ? -mag : mag;
    endfunction

    // Codec side: each valid must answer a request from exactly one cycle earlier.
    always @(posedge clk or posedge rst) begin
        if (rst) req_seen <= 1'b0;
        else     req_seen <= bus.sample_req;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (req_seen || bus.sample_valid)) begin
                check("valid_latency", int'(bus.sample_valid), int'(req_seen));
                if (bus.sample_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_sample", int'($signed(bus.sample_out)), 99999);
                    end else begin
                        e = exp_q.pop_front();
                        check(e.tag, int'($signed(bus.sample_out)), e.val);
                    end
                end
            end
        end
    end

    task automatic do_req(input int val, input string tag, input int gap);
        exp_t e;
        e.val = val;
        e.tag = tag;
        exp_q.push_back(e);
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.sample_req = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic trig(input int intens);
        bus.beat_en        = 1'b1;
        bus.beat_intensity = 2'(intens);
        @(negedge clk);
        bus.beat_en        = 1'b0;
        bus.beat_intensity = 2'd0;
    endtask

    // Samples k_from..k_to of a hit; k_to < 0 runs until the hit has ended.
    task automatic run(input int amp0, input int hp, input int k_from, input int k_to, input string tag);
        int ev;
        for (int k = k_from; (k_to < 0) || (k <= k_to); k++) begin
            ev = hit_sample(amp0, hp, k);
            check($sformatf("%s_busy_k%0d", tag, k), int'(bus.busy), (ev != 0) ? 1 : 0);
            do_req(ev, $sformatf("%s_k%0d", tag, k), (k % 13 == 0) ? 2 : 0);
            if (k_to < 0 && ev == 0) break;
        end
    endtask

    task automatic pulse_reset(input string tag);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_busy"},  int'(bus.busy), 0);
        check({tag, "_out"},   int'($signed(bus.sample_out)), 0);
        check({tag, "_valid"}, int'(bus.sample_valid), 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst                = 1'b1;
        bus.beat_en        = 1'b0;
        bus.beat_intensity = 2'd0;
        bus.sample_req     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy",  int'(bus.busy), 0);
        check("reset_out",   int'($signed(bus.sample_out)), 0);
        check("reset_valid", int'(bus.sample_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        do_req(0, "idle_sample", 1);

        // Intensity 0 must never start a hit.
        trig(0);
        check("int0_busy", int'(bus.busy), 0);
        do_req(0, "int0_sample", 1);

        // Trigger and request in the same cycle: that sample is still silent.
        bus.beat_en        = 1'b1;
        bus.beat_intensity = 2'd1;
        do_req(0, "same_cycle", 0);
        bus.beat_en        = 1'b0;
        bus.beat_intensity = 2'd0;
        check("same_cycle_busy", int'(bus.busy), 1);
        run(8000, 55, 1, -1, "i1");
        check("i1_end_busy", int'(bus.busy), 0);
        do_req(0, "i1_after", 1);

        // Reset in the middle of an intensity-3 hold.
        trig(3);
        run(30000, 27, 1, 100, "i3_pre_rst");
        pulse_reset("mid_rst");
        do_req(0, "post_rst_a", 0);
        do_req(0, "post_rst_b", 1);

        // Lower intensity is ignored, equal intensity restarts the phase.
        trig(3);
        run(30000, 27, 1, 10, "i3");
        trig(2);
        check("lower_ignored_busy", int'(bus.busy), 1);
        run(30000, 27, 11, 40, "i3_keep");
        trig(3);
        run(30000, 27, 1, 30, "i3_equal");

        // Higher intensity restarts an intensity-2 hit.
        pulse_reset("rst_b");
        trig(2);
        run(16000, 40, 1, 5, "i2_pre");
        trig(3);
        run(30000, 27, 1, 30, "i2_to_i3");

        // Complete intensity-2 hit through hold (and decay when enabled).
        pulse_reset("rst_c");
        trig(2);
        run(16000, 40, 1, -1, "i2");
        check("i2_end_busy", int'(bus.busy), 0);
        do_req(0, "i2_after", 1);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
